// File: rtl/word_serializer.sv
// Parallel-to-serial transmitter: captures a WIDTH-bit word and shifts it out
// one bit per accepted beat, with a registered remaining-bit count.
module word_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic             ready,
    output logic             sout,
    output logic             sout_valid,
    input  logic             sout_ready,
    output logic [5:0]       count,
    output logic             done
);

    generate
        if (WIDTH < 1 || WIDTH > 63) begin : g_bad_width
            $error("word_serializer: WIDTH must be in 1..63");
        end
    endgenerate

    localparam logic [5:0] C_WIDTH = 6'(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_shreg;
    logic [WIDTH-1:0] w_shreg_next;
    logic [WIDTH-1:0] w_shifted;
    logic [5:0]       r_count;
    logic [5:0]       w_count_next;
    logic             w_out_bit;

    // Shifts are written as operators so WIDTH=1 needs no special-case slicing.
    assign w_shifted = MSB_FIRST ? (r_shreg << 1) : (r_shreg >> 1);
    assign w_out_bit = MSB_FIRST ? r_shreg[WIDTH-1] : r_shreg[0];
    assign count     = r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_shreg <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_state_next;
            r_shreg <= w_shreg_next;
            r_count <= w_count_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_shreg_next = r_shreg;
        w_count_next = r_count;
        ready        = 1'b0;
        sout         = 1'b0;
        sout_valid   = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                ready = 1'b1;
                if (load) begin
                    w_shreg_next = d;
                    w_count_next = C_WIDTH;
                    w_state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                sout_valid = 1'b1;
                sout       = w_out_bit;
                if (sout_ready) begin
                    w_shreg_next = w_shifted;
                    w_count_next = r_count - 6'd1;
                    if (r_count == 6'd1) begin
                        w_state_next = S_DONE;
                    end
                end
            end
            S_DONE: begin
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                // Unused encoding: scrub the datapath and fall back to IDLE.
                w_state_next = S_IDLE;
                w_shreg_next = '0;
                w_count_next = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_word_serializer.sv
// Bench for word_serializer: queue-based reference model on an 8-bit MSB-first
// instance, plus directed checks on 4-bit LSB-first and 1-bit instances.
module tb_word_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b0;

    logic       load8 = 1'b0;
    logic [7:0] d8 = '0;
    logic       srdy8 = 1'b0;
    logic       ready8, sout8, sv8, done8;
    logic [5:0] cnt8;

    logic       load4 = 1'b0;
    logic [3:0] d4 = '0;
    logic       srdy4 = 1'b0;
    logic       ready4, sout4, sv4, done4;
    logic [5:0] cnt4;

    logic       load1 = 1'b0;
    logic [0:0] d1 = '0;
    logic       srdy1 = 1'b0;
    logic       ready1, sout1, sv1, done1;
    logic [5:0] cnt1;

    word_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut8 (
        .clk(clk), .reset(reset), .load(load8), .d(d8), .ready(ready8),
        .sout(sout8), .sout_valid(sv8), .sout_ready(srdy8), .count(cnt8), .done(done8)
    );

    word_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut4 (
        .clk(clk), .reset(reset), .load(load4), .d(d4), .ready(ready4),
        .sout(sout4), .sout_valid(sv4), .sout_ready(srdy4), .count(cnt4), .done(done4)
    );

    word_serializer #(.WIDTH(1), .MSB_FIRST(1'b1)) dut1 (
        .clk(clk), .reset(reset), .load(load1), .d(d1), .ready(ready1),
        .sout(sout1), .sout_valid(sv1), .sout_ready(srdy1), .count(cnt1), .done(done1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the bits still owed to the consumer, in send order.
    bit q8[$];
    bit done_m8 = 1'b0;

    logic [7:0] cap8;
    int         edges8;

    typedef struct {
        logic [7:0] d;
        bit         seq [8];
    } vec_t;
    vec_t tbl [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset8();
        q8.delete();
        done_m8 = 1'b0;
    endtask

    task automatic model_edge8();
        bit nd;
        bit dummy;
        nd = 1'b0;
        if (q8.size() == 0 && !done_m8) begin
            if (load8) begin
                for (int i = 7; i >= 0; i--) q8.push_back(d8[i]);
            end
        end else if (q8.size() != 0 && srdy8) begin
            dummy = q8.pop_front();
            if (q8.size() == 0) nd = 1'b1;
        end
        done_m8 = nd;
    endtask

    task automatic check_model8();
        chk("m_valid", 32'(sv8), 32'(q8.size() != 0));
        chk("m_sout", 32'(sout8), (q8.size() != 0) ? 32'(q8[0]) : 32'd0);
        chk("m_count", 32'(cnt8), 32'(q8.size()));
        chk("m_done", 32'(done8), 32'(done_m8));
        chk("m_ready", 32'(ready8), 32'(q8.size() == 0 && !done_m8));
    endtask

    task automatic cycle();
        @(posedge clk);
        if (reset) model_reset8();
        else model_edge8();
        #1;
        check_model8();
    endtask

    // Run until done8 rises, capturing accepted bits into cap8.
    task automatic run_to_done8(input int limit);
        edges8 = 0;
        while (!done8 && edges8 < limit) begin
            if (sv8 && srdy8) cap8 = {cap8[6:0], sout8};
            cycle();
            edges8++;
        end
        chk("done_timeout", 32'(done8), 32'd1);
    endtask

    initial begin
        tbl[0].d = 8'hA5; tbl[0].seq = '{1, 0, 1, 0, 0, 1, 0, 1};
        tbl[1].d = 8'h0F; tbl[1].seq = '{0, 0, 0, 0, 1, 1, 1, 1};
        tbl[2].d = 8'h81; tbl[2].seq = '{1, 0, 0, 0, 0, 0, 0, 1};
        tbl[3].d = 8'h6E; tbl[3].seq = '{0, 1, 1, 0, 1, 1, 1, 0};

        // Asynchronous reset with no clock edge.
        #2 reset = 1'b1;
        #1;
        chk("rst_count", 32'(cnt8), 32'd0);
        chk("rst_valid", 32'(sv8), 32'd0);
        chk("rst_ready", 32'(ready8), 32'd1);
        chk("rst_done", 32'(done8), 32'd0);
        chk("rst_sout", 32'(sout8), 32'd0);
        model_reset8();
        cycle();
        cycle();
        reset = 1'b0;
        cycle();

        // Table vectors, sout_ready held high.
        srdy8 = 1'b1;
        for (int v = 0; v < 4; v++) begin
            load8 = 1'b1;
            d8 = tbl[v].d;
            cycle();
            load8 = 1'b0;
            for (int i = 0; i < 8; i++) begin
                chk("tbl_sout", 32'(sout8), 32'(tbl[v].seq[i]));
                chk("tbl_count", 32'(cnt8), 32'(8 - i));
                cycle();
            end
            chk("tbl_done", 32'(done8), 32'd1);
            chk("tbl_done_count", 32'(cnt8), 32'd0);
            cycle();
            chk("tbl_ready_after", 32'(ready8), 32'd1);
            chk("tbl_done_gone", 32'(done8), 32'd0);
        end

        // Backpressure: stall three cycles after the second beat.
        load8 = 1'b1; d8 = 8'h3C; srdy8 = 1'b1;
        cycle();
        load8 = 1'b0;
        cap8 = '0;
        for (int i = 0; i < 2; i++) begin
            cap8 = {cap8[6:0], sout8};
            cycle();
        end
        srdy8 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("bp_sout_hold", 32'(sout8), 32'd1);
            chk("bp_count_hold", 32'(cnt8), 32'd6);
        end
        srdy8 = 1'b1;
        run_to_done8(40);
        chk("bp_word", 32'(cap8), 32'h3C);
        // Edges after the load edge until done: 8 beats + 3 stalls.
        chk("bp_latency", 32'(2 + 3 + edges8), 32'd11);
        cycle();

        // Loads during SHIFT and DONE are ignored.
        load8 = 1'b1; d8 = 8'h81;
        cycle();
        cap8 = '0;
        d8 = 8'hFF;
        cap8 = {cap8[6:0], sout8};
        cycle();
        load8 = 1'b0;
        run_to_done8(40);
        load8 = 1'b1; d8 = 8'hFF;
        cycle();
        load8 = 1'b0;
        chk("ign_word", 32'(cap8), 32'h81);
        chk("ign_ready", 32'(ready8), 32'd1);
        chk("ign_valid", 32'(sv8), 32'd0);
        cycle();
        chk("ign_still_idle", 32'(sv8), 32'd0);

        // Reset mid-word abandons it without a done pulse.
        load8 = 1'b1; d8 = 8'hF0;
        cycle();
        load8 = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        chk("mid_count_before", 32'(cnt8), 32'd5);
        #2 reset = 1'b1;
        #1;
        model_reset8();
        chk("mid_rst_count", 32'(cnt8), 32'd0);
        chk("mid_rst_valid", 32'(sv8), 32'd0);
        chk("mid_rst_done", 32'(done8), 32'd0);
        chk("mid_rst_ready", 32'(ready8), 32'd1);
        cycle();
        reset = 1'b0;
        cycle();
        chk("mid_no_done", 32'(done8), 32'd0);
        load8 = 1'b1; d8 = 8'h0F;
        cycle();
        load8 = 1'b0;
        cap8 = '0;
        run_to_done8(40);
        chk("mid_next_word", 32'(cap8), 32'h0F);
        cycle();

        // LSB-first, WIDTH=4: 4'b0110 goes out as 0,1,1,0.
        load4 = 1'b1; d4 = 4'b0110; srdy4 = 1'b1;
        cycle();
        load4 = 1'b0;
        begin
            bit exp4 [4];
            exp4 = '{0, 1, 1, 0};
            for (int i = 0; i < 4; i++) begin
                chk("lsb_sout", 32'(sout4), 32'(exp4[i]));
                chk("lsb_count", 32'(cnt4), 32'(4 - i));
                cycle();
            end
        end
        chk("lsb_done", 32'(done4), 32'd1);
        cycle();
        chk("lsb_ready", 32'(ready4), 32'd1);

        // WIDTH=1: one beat then DONE.
        load1 = 1'b1; d1 = 1'b1; srdy1 = 1'b1;
        cycle();
        load1 = 1'b0;
        chk("w1_valid", 32'(sv1), 32'd1);
        chk("w1_sout", 32'(sout1), 32'd1);
        chk("w1_count", 32'(cnt1), 32'd1);
        cycle();
        chk("w1_done", 32'(done1), 32'd1);
        chk("w1_done_count", 32'(cnt1), 32'd0);
        cycle();
        chk("w1_ready", 32'(ready1), 32'd1);

        // Random traffic against the reference model.
        for (int n = 0; n < 600; n++) begin
            load8 = ($urandom_range(0, 2) == 0);
            d8    = 8'($urandom);
            srdy8 = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
